// File: rtl/cve2_obi_sram_bridge_if.sv
// rtl/cve2_obi_sram_bridge_if.sv - instr/data OBI ports and SRAM port of the bridge, bundled
interface cve2_obi_sram_bridge_if #(
  parameter int unsigned AwW = 12
);
  logic           instr_req_i;
  logic           instr_gnt_o;
  logic [31:0]    instr_addr_i;
  logic           instr_rvalid_o;
  logic [31:0]    instr_rdata_o;
  logic           instr_err_o;

  logic           data_req_i;
  logic           data_gnt_o;
  logic           data_we_i;
  logic [3:0]     data_be_i;
  logic [31:0]    data_addr_i;
  logic [31:0]    data_wdata_i;
  logic           data_rvalid_o;
  logic [31:0]    data_rdata_o;
  logic           data_err_o;

  logic           sram_req_o;
  logic           sram_we_o;
  logic [3:0]     sram_be_o;
  logic [AwW-1:0] sram_addr_o;
  logic [31:0]    sram_wdata_o;
  logic [31:0]    sram_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output sram_req_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o,
    input  sram_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  sram_req_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o,
    output sram_rdata_i
  );
endinterface

// File: rtl/cve2_obi_sram_bridge.sv
// rtl/cve2_obi_sram_bridge.sv - arbitrates instr/data OBI requests onto one 1-cycle-latency SRAM
module cve2_obi_sram_bridge #(
  parameter int unsigned MemWords = 4096,
  parameter logic [31:0] BaseAddr = 32'h0,
  localparam int unsigned AwW = $clog2(MemWords)
) (
  input logic clk_i,
  input logic rst_i,
  cve2_obi_sram_bridge_if.slave bus
);

  typedef enum logic {LAST_INSTR, LAST_DATA} last_e;

  last_e last_q;
  logic  instr_rvalid_q, instr_err_q, instr_rd_q;
  logic  data_rvalid_q, data_err_q, data_rd_q;

  logic [31:0] instr_off, data_off;
  logic        instr_in_range, data_in_range;
  logic        gnt_instr, gnt_data;
  logic        acc_instr, acc_data;
  logic        unused_low_bits;

  // BaseAddr is word aligned, so offset[1:0] is just addr[1:0] and is ignored.
  assign instr_off      = bus.instr_addr_i - BaseAddr;
  assign data_off       = bus.data_addr_i - BaseAddr;
  assign instr_in_range = instr_off[31:2] < 30'(MemWords);
  assign data_in_range  = data_off[31:2] < 30'(MemWords);
  assign unused_low_bits = ^{instr_off[1:0], data_off[1:0]};

  always_comb begin
    gnt_data  = 1'b0;
    gnt_instr = 1'b0;
    if (!rst_i) begin
      gnt_data  = bus.data_req_i && (!bus.instr_req_i || last_q == LAST_INSTR);
      gnt_instr = bus.instr_req_i && !gnt_data;
    end
  end

  assign acc_instr = gnt_instr && instr_in_range;
  assign acc_data  = gnt_data && data_in_range;

  assign bus.instr_gnt_o  = gnt_instr;
  assign bus.data_gnt_o   = gnt_data;
  assign bus.sram_req_o   = acc_instr || acc_data;
  assign bus.sram_we_o    = acc_data && bus.data_we_i;
  assign bus.sram_be_o    = acc_data ? bus.data_be_i : (acc_instr ? 4'hF : 4'h0);
  assign bus.sram_wdata_o = (acc_data && bus.data_we_i) ? bus.data_wdata_i : 32'h0;
  assign bus.sram_addr_o  = acc_data  ? data_off[AwW+1:2] :
                            acc_instr ? instr_off[AwW+1:2] : '0;

  // Responses are masked while reset is held so nothing pending escapes.
  assign bus.instr_rvalid_o = instr_rvalid_q && !rst_i;
  assign bus.instr_err_o    = instr_err_q && !rst_i;
  assign bus.instr_rdata_o  = (instr_rd_q && !rst_i) ? bus.sram_rdata_i : 32'h0;
  assign bus.data_rvalid_o  = data_rvalid_q && !rst_i;
  assign bus.data_err_o     = data_err_q && !rst_i;
  assign bus.data_rdata_o   = (data_rd_q && !rst_i) ? bus.sram_rdata_i : 32'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q         <= LAST_INSTR;
      instr_rvalid_q <= 1'b0;
      instr_err_q    <= 1'b0;
      instr_rd_q     <= 1'b0;
      data_rvalid_q  <= 1'b0;
      data_err_q     <= 1'b0;
      data_rd_q      <= 1'b0;
    end else begin
      instr_rvalid_q <= gnt_instr;
      instr_err_q    <= gnt_instr && !instr_in_range;
      instr_rd_q     <= acc_instr;
      data_rvalid_q  <= gnt_data;
      data_err_q     <= gnt_data && !data_in_range;
      data_rd_q      <= acc_data && !bus.data_we_i;
      if (gnt_data) begin
        last_q <= LAST_DATA;
      end else if (gnt_instr) begin
        last_q <= LAST_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_cve2_obi_sram_bridge.sv
// tb/tb_cve2_obi_sram_bridge.sv - directed self-checking bench for cve2_obi_sram_bridge
module tb_cve2_obi_sram_bridge;
  localparam int unsigned MemWords = 64;
  localparam int unsigned AwW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cve2_obi_sram_bridge_if #(.AwW(AwW)) bus ();

  cve2_obi_sram_bridge #(.MemWords(MemWords), .BaseAddr(32'h0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // SRAM model: byte-enabled writes, read data one cycle after the strobe
  logic [31:0] mem [0:MemWords-1];
  always @(posedge clk) begin
    if (bus.sram_req_o) begin
      if (bus.sram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_be_o[b]) mem[bus.sram_addr_o][8*b +: 8] <= bus.sram_wdata_o[8*b +: 8];
      end else begin
        bus.sram_rdata_i <= mem[bus.sram_addr_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [3:0] db,
                       input logic [31:0] da, input logic [31:0] dwd);
    @(negedge clk);
    rst               = rs;
    bus.instr_req_i   = ir;
    bus.instr_addr_i  = ia;
    bus.data_req_i    = dr;
    bus.data_we_i     = dw;
    bus.data_be_i     = db;
    bus.data_addr_i   = da;
    bus.data_wdata_i  = dwd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = 32'h0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'h0;
    bus.data_addr_i  = 32'h0;
    bus.data_wdata_i = 32'h0;
    bus.sram_rdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr_gnt", bus.instr_gnt_o, 0);
    chk("rst_data_gnt", bus.data_gnt_o, 0);
    chk("rst_instr_rvalid", bus.instr_rvalid_o, 0);
    chk("rst_data_rvalid", bus.data_rvalid_o, 0);
    chk("rst_data_rdata", bus.data_rdata_o, 0);
    chk("rst_sram_req", bus.sram_req_o, 0);

    drive(1, 1, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
    chk("rst_req_instr_gnt", bus.instr_gnt_o, 0);
    chk("rst_req_data_gnt", bus.data_gnt_o, 0);
    chk("rst_req_sram_req", bus.sram_req_o, 0);
    tick();

    drive(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("idle_sram_req", bus.sram_req_o, 0);
    chk("idle_sram_addr", bus.sram_addr_o, 0);
    tick();
    chk("idle_data_rvalid", bus.data_rvalid_o, 0);

    drive(0, 0, 32'h0, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
    chk("wr_data_gnt", bus.data_gnt_o, 1);
    chk("wr_instr_gnt", bus.instr_gnt_o, 0);
    chk("wr_sram_req", bus.sram_req_o, 1);
    chk("wr_sram_we", bus.sram_we_o, 1);
    chk("wr_sram_addr", bus.sram_addr_o, 4);
    chk("wr_sram_be", bus.sram_be_o, 4'hF);
    chk("wr_sram_wdata", bus.sram_wdata_o, 32'hDEADBEEF);
    tick();
    chk("wr_rvalid", bus.data_rvalid_o, 1);
    chk("wr_err", bus.data_err_o, 0);
    chk("wr_rdata", bus.data_rdata_o, 0);
    chk("wr_instr_rvalid", bus.instr_rvalid_o, 0);

    drive(0, 0, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
    chk("rd_data_gnt", bus.data_gnt_o, 1);
    chk("rd_sram_addr", bus.sram_addr_o, 4);
    chk("rd_sram_we", bus.sram_we_o, 0);
    tick();
    chk("rd_rvalid", bus.data_rvalid_o, 1);
    chk("rd_rdata", bus.data_rdata_o, 32'hDEADBEEF);
    chk("rd_err", bus.data_err_o, 0);

    drive(0, 0, 32'h0, 1, 0, 4'hF, 32'h100, 32'h0);
    chk("oor_gnt", bus.data_gnt_o, 1);
    chk("oor_sram_req", bus.sram_req_o, 0);
    tick();
    chk("oor_rvalid", bus.data_rvalid_o, 1);
    chk("oor_err", bus.data_err_o, 1);
    chk("oor_rdata", bus.data_rdata_o, 0);

    drive(0, 0, 32'h0, 1, 0, 4'hF, 32'h0FF, 32'h0);
    chk("edge_sram_req", bus.sram_req_o, 1);
    chk("edge_sram_addr", bus.sram_addr_o, 63);
    tick();
    chk("edge_err", bus.data_err_o, 0);

    drive(0, 0, 32'h0, 1, 1, 4'hF, 32'h20, 32'h11223344);
    tick();
    drive(0, 0, 32'h0, 1, 1, 4'b0010, 32'h20, 32'h0000AB00);
    chk("byte_sram_be", bus.sram_be_o, 4'b0010);
    tick();
    drive(0, 0, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0);
    tick();
    chk("byte_rdata", bus.data_rdata_o, 32'h1122AB44);

    // Data wins the last grant, so without the reset instr would win next
    drive(0, 0, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
    chk("mid_gnt", bus.data_gnt_o, 1);
    drive(1, 1, 32'h10, 1, 0, 4'hF, 32'h20, 32'h0);
    chk("mid_rst_data_rvalid", bus.data_rvalid_o, 0);
    chk("mid_rst_data_gnt", bus.data_gnt_o, 0);
    chk("mid_rst_instr_gnt", bus.instr_gnt_o, 0);
    tick();
    chk("mid_rst_rvalid_after", bus.data_rvalid_o, 0);
    drive(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("post_rst_data_rvalid", bus.data_rvalid_o, 0);
    chk("post_rst_instr_rvalid", bus.instr_rvalid_o, 0);

    for (int k = 0; k < 6; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      drive(0, 1, 32'h10, 1, 0, 4'hF, 32'h20, 32'h0);
      chk($sformatf("alt%0d_data_gnt", k), bus.data_gnt_o, exp_d);
      chk($sformatf("alt%0d_instr_gnt", k), bus.instr_gnt_o, !exp_d);
      tick();
      chk($sformatf("alt%0d_data_rvalid", k), bus.data_rvalid_o, exp_d);
      chk($sformatf("alt%0d_instr_rvalid", k), bus.instr_rvalid_o, !exp_d);
      if (exp_d) chk($sformatf("alt%0d_data_rdata", k), bus.data_rdata_o, 32'h1122AB44);
      else       chk($sformatf("alt%0d_instr_rdata", k), bus.instr_rdata_o, 32'hDEADBEEF);
    end
    drive(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("alt_end_instr_rvalid", bus.instr_rvalid_o, 0);

    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 32'h0, 1, 1, 4'hF, 32'(i * 4), 32'hC0DE0000 + 32'(i * 32'h111));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 32'(i * 4), 0, 0, 4'h0, 32'h0, 32'h0);
      chk($sformatf("fetch%0d_gnt", i), bus.instr_gnt_o, 1);
      chk($sformatf("fetch%0d_sram_addr", i), bus.sram_addr_o, 32'(i));
      chk($sformatf("fetch%0d_sram_be", i), bus.sram_be_o, 4'hF);
      tick();
      chk($sformatf("fetch%0d_rvalid", i), bus.instr_rvalid_o, 1);
      chk($sformatf("fetch%0d_rdata", i), bus.instr_rdata_o, 32'hC0DE0000 + 32'(i * 32'h111));
    end
    drive(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("fetch_end_rvalid", bus.instr_rvalid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
